letter_code_scroller: RTL and testbench

//  Producer side of the 5-bit letter-code display interface. Accepts an ASCII message

---
 rtl/letter_code_scroller_pkg.sv | 35 +++
 rtl/letter_code_scroller_if.sv | 10 +
 rtl/letter_code_scroller_ascii_to_letter_code.sv | 40 ++++
 rtl/letter_code_scroller.sv | 114 +++++++++++
 tb/tb_letter_code_scroller.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/letter_code_scroller_pkg.sv
// Letter-code constants and scroller FSM states, shared with the per-digit segment decoder.
package letter_code_pkg;

  localparam int CODE_W = 5;

  typedef logic [CODE_W-1:0] code_t;

  localparam code_t CODE_UNDERSCORE = 5'd0;
  localparam code_t CODE_A          = 5'd1;
  localparam code_t CODE_B          = 5'd2;
  localparam code_t CODE_C          = 5'd3;
  localparam code_t CODE_D          = 5'd4;
  localparam code_t CODE_E          = 5'd5;
  localparam code_t CODE_F          = 5'd6;
  localparam code_t CODE_G          = 5'd7;
  localparam code_t CODE_H          = 5'd8;
  localparam code_t CODE_J          = 5'd9;
  localparam code_t CODE_L          = 5'd10;
  localparam code_t CODE_N          = 5'd11;
  localparam code_t CODE_O          = 5'd12;
  localparam code_t CODE_P          = 5'd13;
  localparam code_t CODE_Q          = 5'd14;
  localparam code_t CODE_R          = 5'd15;
  localparam code_t CODE_S          = 5'd16;
  localparam code_t CODE_U          = 5'd17;
  localparam code_t CODE_Y          = 5'd18;
  localparam code_t CODE_HOLD       = 5'd20;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SCROLL
  } state_t;

endpackage

// File: rtl/letter_code_scroller_if.sv
// Valid/ready byte stream carrying the ASCII message into the scroller.
interface letter_code_scroller_if;
  logic [7:0] in_char;
  logic       in_valid;
  logic       in_last;
  logic       in_ready;

  modport master (output in_char, output in_valid, output in_last, input in_ready);
  modport slave  (input in_char, input in_valid, input in_last, output in_ready);
endinterface

// File: rtl/letter_code_scroller_ascii_to_letter_code.sv
// Combinational ASCII -> 5-bit letter code; unmapped bytes become the underscore code.
module ascii_to_letter_code
  import letter_code_pkg::*;
(
  input  logic [7:0] ascii,
  output code_t      code
);

  logic [7:0] upper;

  always_comb begin
    upper = ascii;
    if (ascii >= 8'h61 && ascii <= 8'h7a) upper = ascii & 8'hdf;
    code = CODE_UNDERSCORE;
    case (upper)
      "A": code = CODE_A;
      "B": code = CODE_B;
      "C": code = CODE_C;
      "D": code = CODE_D;
      "E": code = CODE_E;
      "F": code = CODE_F;
      "G": code = CODE_G;
      "H": code = CODE_H;
      "J": code = CODE_J;
      "L": code = CODE_L;
      "N": code = CODE_N;
      "O": code = CODE_O;
      "P": code = CODE_P;
      "Q": code = CODE_Q;
      "R": code = CODE_R;
      "S": code = CODE_S;
      "U": code = CODE_U;
      "Y": code = CODE_Y;
      "0": code = CODE_O;
      "5": code = CODE_S;
      default: code = CODE_UNDERSCORE;
    endcase
  end

endmodule

// File: rtl/letter_code_scroller.sv
// Buffers an encoded message and scrolls a DIGITS-wide wrapping window across it.
module letter_code_scroller
  import letter_code_pkg::*;
#(
  parameter int DIGITS     = 4,
  parameter int DEPTH      = 16,
  parameter int STEP_TICKS = 100_000_000
) (
  input  logic                       clk,
  input  logic                       rst,
  letter_code_scroller_if.slave      stream,
  input  logic                       clear,
  input  logic                       scroll_en,
  output logic [CODE_W*DIGITS-1:0]   code_out,
  output logic                       busy
);

  localparam int IW = $clog2(DEPTH);
  localparam int LW = IW + 1;
  localparam int TW = $clog2(STEP_TICKS);

  state_t             state, state_nxt;
  logic [LW-1:0]      len;
  logic [IW-1:0]      start;
  logic [TW-1:0]      ticks;
  code_t              buffer [DEPTH];
  code_t              wr_code;
  logic               ready;
  logic               accept;
  logic [CODE_W*DIGITS-1:0] window;
  logic [IW-1:0]      cur;
  logic [LW-1:0]      cur_inc;
  logic [LW-1:0]      start_inc;

  ascii_to_letter_code u_enc (
    .ascii (stream.in_char),
    .code  (wr_code)
  );

  assign stream.in_ready = ready;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    busy      = 1'b0;
    accept    = 1'b0;
    case (state)
      ST_IDLE:   ready = 1'b1;
      ST_LOAD: begin
        busy  = 1'b1;
        ready = (len < LW'(DEPTH));
      end
      ST_SCROLL: busy = 1'b1;
      default:   state_nxt = ST_IDLE;
    endcase
    if (rst || clear) ready = 1'b0;
    accept = stream.in_valid && ready;
    if (accept) begin
      if (stream.in_last || len == LW'(DEPTH - 1)) state_nxt = ST_SCROLL;
      else                                         state_nxt = ST_LOAD;
    end
    if (clear) state_nxt = ST_IDLE;
  end

  // Successive indices wrap by a single compare, so no modulo is needed even when len < DIGITS.
  always_comb begin
    window  = '0;
    cur     = start;
    cur_inc = '0;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      window[CODE_W*k +: CODE_W] = buffer[cur];
      cur_inc = {1'b0, cur} + LW'(1);
      cur     = (cur_inc >= len) ? '0 : cur_inc[IW-1:0];
    end
  end

  assign start_inc = {1'b0, start} + LW'(1);

  always_ff @(posedge clk) begin
    if (accept) buffer[len[IW-1:0]] <= wr_code;
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      len      <= '0;
      start    <= '0;
      ticks    <= '0;
      code_out <= '0;
    end else begin
      if (accept) len <= len + LW'(1);
      if (state == ST_SCROLL) begin
        code_out <= window;
        if (scroll_en) begin
          if (ticks == TW'(STEP_TICKS - 1)) begin
            ticks <= '0;
            start <= (start_inc >= len) ? '0 : start_inc[IW-1:0];
          end else begin
            ticks <= ticks + TW'(1);
          end
        end
      end else begin
        start    <= '0;
        ticks    <= '0;
        code_out <= '0;
      end
    end
  end

endmodule

// File: tb/tb_letter_code_scroller.sv
// Randomized scoreboard bench: the driver predicts per-cycle outputs from a message-level model.
module tb_letter_code_scroller;

  localparam int DIGITS = 4;
  localparam int DEPTH  = 16;
  localparam int STEP   = 4;

  logic clk = 1'b0;
  logic rst, clear, scroll_en, busy;
  logic [5*DIGITS-1:0] code_out;

  letter_code_scroller_if bus ();

  letter_code_scroller #(
    .DIGITS     (DIGITS),
    .DEPTH      (DEPTH),
    .STEP_TICKS (STEP)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .stream    (bus.slave),
    .clear     (clear),
    .scroll_en (scroll_en),
    .code_out  (code_out),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int          cyc;
    int          kind;
    logic [31:0] val;
    string       name;
  } exp_t;
  exp_t sb[$];

  typedef bit [7:0] bq_t[$];
  typedef enum {M_IDLE, M_LOAD, M_SCROLL} mph_t;
  mph_t        ph = M_IDLE;
  int unsigned msg[$];
  int          n_en = 0;
  string       tag = "init";

  function automatic int unsigned encode(bit [7:0] ch);
    string    alpha;
    bit [7:0] c;
    alpha = "ABCDEFGHJLNOPQRSUY";
    c = ch;
    if (c >= 8'h61 && c <= 8'h7a) c = c - 8'h20;
    if (c == "0") return 12;
    if (c == "5") return 16;
    for (int i = 0; i < alpha.len(); i++)
      if (8'(alpha[i]) == c) return i + 1;
    return 0;
  endfunction

  // Window position is the number of enabled scroll cycles divided by the step length.
  function automatic logic [5*DIGITS-1:0] window();
    logic [5*DIGITS-1:0] w;
    int len, s;
    w   = '0;
    len = msg.size();
    s   = (n_en / STEP) % len;
    for (int k = 0; k < DIGITS; k++) w[5*k +: 5] = 5'(msg[(s + k) % len]);
    return w;
  endfunction

  function automatic bq_t s2q(string s);
    bq_t q;
    for (int i = 0; i < s.len(); i++) q.push_back(8'(s[i]));
    return q;
  endfunction

  task automatic push(int c, int kind, logic [31:0] v, string nm);
    exp_t e;
    e.cyc = c; e.kind = kind; e.val = v; e.name = {tag, "/", nm};
    sb.push_back(e);
  endtask

  task automatic step(bit r, bit clr, bit v, bit [7:0] ch, bit last, bit en);
    bit rdy;
    rst = r; clear = clr; scroll_en = en;
    bus.in_valid = v; bus.in_char = ch; bus.in_last = last;
    rdy = !r && !clr && (ph == M_IDLE || (ph == M_LOAD && msg.size() < DEPTH));
    push(cyc, 1, 32'(rdy), "in_ready");
    push(cyc, 2, 32'(ph != M_IDLE), "busy");
    push(cyc + 1, 0, (!r && !clr && ph == M_SCROLL) ? 32'(window()) : 32'd0, "code_out");
    if (r || clr) begin
      ph = M_IDLE; msg.delete(); n_en = 0;
    end else if (v && rdy) begin
      msg.push_back(encode(ch));
      if (last || msg.size() == DEPTH) begin ph = M_SCROLL; n_en = 0; end
      else ph = M_LOAD;
    end else if (ph == M_SCROLL && en) begin
      n_en++;
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 8'h00, 0, 1);
  endtask

  // mode 0: scroll_en=1, 1: frozen, 2: random
  task automatic scroll(int n, int mode);
    for (int i = 0; i < n; i++)
      step(0, 0, 0, 8'h00, 0, mode == 0 ? 1'b1 : mode == 1 ? 1'b0 : 1'($urandom_range(0, 1)));
  endtask

  task automatic send(bq_t q, bit with_last, bit gaps);
    for (int i = 0; i < q.size(); i++) begin
      if (gaps && $urandom_range(0, 3) == 0) step(0, 0, 0, 8'h00, 0, 1'($urandom_range(0, 1)));
      step(0, 0, 1, q[i], with_last && (i == q.size() - 1), 1);
    end
  endtask

  function automatic bit [7:0] rand_char();
    case ($urandom_range(0, 3))
      0:       return 8'(65 + $urandom_range(0, 25));
      1:       return 8'(97 + $urandom_range(0, 25));
      2:       return 8'(48 + $urandom_range(0, 9));
      default: return 8'($urandom_range(0, 255));
    endcase
  endfunction

  always @(negedge clk) begin
    exp_t e;
    logic [31:0] act;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      act = (e.kind == 0) ? 32'(code_out) : (e.kind == 1) ? 32'(bus.in_ready) : 32'(busy);
      n_tests++;
      if (e.cyc != cyc || act !== e.val) begin
        n_fail++;
        $display("FAIL %s cyc=%0d due=%0d got=%h want=%h", e.name, cyc, e.cyc, act, e.val);
      end
    end
  end

  initial begin
    bq_t q;
    rst = 1'b1; clear = 1'b0; scroll_en = 1'b0;
    bus.in_valid = 1'b0; bus.in_char = 8'h00; bus.in_last = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tag = "reset";
    step(1, 0, 0, 8'h00, 0, 0);
    idle(2);

    tag = "hello";
    send(s2q("HELLO"), 1, 0);
    scroll(25, 0);
    step(0, 1, 0, 8'h00, 0, 1);

    tag = "ab?z";
    send(s2q("ab?z"), 1, 0);
    scroll(8, 0);
    step(0, 1, 0, 8'h00, 0, 1);

    tag = "overflow";
    q.delete();
    for (int i = 0; i < 17; i++) q.push_back(8'(65 + $urandom_range(0, 25)));
    send(q, 0, 0);
    scroll(70, 0);
    step(0, 1, 1, "A", 1, 1);
    idle(2);

    tag = "ce_freeze";
    send(s2q("CE"), 1, 0);
    scroll(6, 0);
    scroll(10, 1);
    scroll(10, 0);
    step(1, 0, 1, "B", 1, 1);
    idle(2);

    tag = "abort";
    send(s2q("ABC"), 0, 0);
    step(0, 1, 1, "D", 1, 1);
    idle(2);
    send(s2q("XYZW"), 0, 0);
    step(1, 0, 1, "Q", 0, 1);
    idle(2);

    for (int t = 0; t < 12; t++) begin
      tag = $sformatf("rand%0d", t);
      q.delete();
      for (int i = 0; i < $urandom_range(1, 20); i++) q.push_back(rand_char());
      send(q, 1'($urandom_range(0, 1)), 1);
      scroll($urandom_range(10, 60), 2);
      if ($urandom_range(0, 1) == 1) step(0, 1, 1'($urandom_range(0, 1)), rand_char(), 1, 1);
      else                           step(1, 0, 1'($urandom_range(0, 1)), rand_char(), 1, 1);
      idle(1);
    end

    repeat (3) @(negedge clk);
    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_drain got=%0d want=0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
